// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780-style LCD write controller.
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    WAIT
  } lcd_state_t;

  localparam int CNT_W    = 19;
  localparam int INIT_CNT = 6;
  localparam logic [2:0] INIT_LAST = 3'(INIT_CNT - 1);

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  localparam logic [7:0] INIT_FUNC_SET = 8'h38;
  localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
  localparam logic [7:0] INIT_CLEAR    = OP_CLEAR;
  localparam logic [7:0] INIT_ENTRY    = 8'h06;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_cmd = INIT_FUNC_SET;
      3'd3:             init_cmd = INIT_DISP_ON;
      3'd4:             init_cmd = INIT_CLEAR;
      3'd5:             init_cmd = INIT_ENTRY;
      default:          init_cmd = 8'h00;
    endcase
  endfunction

  // Down-counter load value for an N-cycle phase; zero-length phases run one cycle.
  function automatic logic [CNT_W-1:0] phase_load(input int n);
    phase_load = (n <= 1) ? '0 : CNT_W'(n - 1);
  endfunction

  function automatic logic is_long_write(input logic rs, input logic [7:0] data);
    is_long_write = !rs && (data == OP_CLEAR || data == OP_HOME || data == OP_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter; zero flags the last cycle of the current phase.
module lcd_phase_timer
  import lcd_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// LCD write sequencer: power-up init list, then one host write per accept,
// each framed as SETUP / EN_HI / HOLD / WAIT.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int T_SETUP      = 2,
  parameter int T_EN         = 13,
  parameter int T_HOLD       = 2,
  parameter int T_WAIT_SHORT = 1100,
  parameter int T_WAIT_LONG  = 44300,
  parameter int T_POWERUP    = 405000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  localparam logic [CNT_W-1:0] LD_PWRUP = phase_load(T_POWERUP);
  localparam logic [CNT_W-1:0] LD_SETUP = phase_load(T_SETUP);
  // The IDLE accept cycle counts as the first setup cycle, so host writes
  // repeat at exactly T_SETUP+T_EN+T_HOLD+T_WAIT with no idle gap.
  localparam logic [CNT_W-1:0] LD_SETUP_ACC = phase_load(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN    = phase_load(T_EN);
  localparam logic [CNT_W-1:0] LD_HOLD  = phase_load(T_HOLD);
  localparam logic [CNT_W-1:0] LD_SHORT = phase_load(T_WAIT_SHORT);
  localparam logic [CNT_W-1:0] LD_LONG  = phase_load(T_WAIT_LONG);

  lcd_state_t       state, state_nxt;
  logic [2:0]       init_idx, idx_nxt;
  logic             done_nxt;
  logic             bus_ld, rs_nxt;
  logic [7:0]       data_nxt;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  lcd_phase_timer #(
    .RST_VAL (LD_PWRUP)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign req_ready = (state == IDLE) && init_done;
  assign lcd_rw    = 1'b0;

  always_comb begin
    state_nxt = state;
    idx_nxt   = init_idx;
    done_nxt  = init_done;
    bus_ld    = 1'b0;
    rs_nxt    = lcd_rs;
    data_nxt  = lcd_data;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      PWRUP: begin
        if (tmr_zero) begin
          state_nxt = SETUP;
          idx_nxt   = '0;
          bus_ld    = 1'b1;
          rs_nxt    = 1'b0;
          data_nxt  = init_cmd(3'd0);
          tmr_load  = 1'b1;
          tmr_val   = LD_SETUP;
        end
      end
      IDLE: begin
        if (req_valid && req_ready) begin
          state_nxt = SETUP;
          bus_ld    = 1'b1;
          rs_nxt    = req_rs;
          data_nxt  = req_data;
          tmr_load  = 1'b1;
          tmr_val   = LD_SETUP_ACC;
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          state_nxt = EN_HI;
          tmr_load  = 1'b1;
          tmr_val   = LD_EN;
        end
      end
      EN_HI: begin
        if (tmr_zero) begin
          state_nxt = HOLD;
          tmr_load  = 1'b1;
          tmr_val   = LD_HOLD;
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_nxt = WAIT;
          tmr_load  = 1'b1;
          tmr_val   = is_long_write(lcd_rs, lcd_data) ? LD_LONG : LD_SHORT;
        end
      end
      WAIT: begin
        if (tmr_zero) begin
          if (init_done) begin
            state_nxt = IDLE;
          end else if (init_idx == INIT_LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = SETUP;
            idx_nxt   = init_idx + 3'd1;
            bus_ld    = 1'b1;
            rs_nxt    = 1'b0;
            data_nxt  = init_cmd(init_idx + 3'd1);
            tmr_load  = 1'b1;
            tmr_val   = LD_SETUP;
          end
        end
      end
      default: state_nxt = PWRUP;
    endcase
  end

  // lcd_en is registered from the next state so the strobe comes straight off a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= PWRUP;
      init_idx  <= '0;
      init_done <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
    end else begin
      state     <= state_nxt;
      init_idx  <= idx_nxt;
      init_done <= done_nxt;
      lcd_en    <= (state_nxt == EN_HI);
      if (bus_ld) begin
        lcd_rs   <= rs_nxt;
        lcd_data <= data_nxt;
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  lcd_ctrl #(
    .T_SETUP      (2),
    .T_EN         (3),
    .T_HOLD       (2),
    .T_WAIT_SHORT (5),
    .T_WAIT_LONG  (20),
    .T_POWERUP    (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .req_ready (req_ready),
    .init_done (init_done),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // EN pulse monitor
  int         cyc = 0;
  logic       en_prev = 1'b0;
  int         cur_len = 0;
  logic       rw_bad = 1'b0;
  logic [7:0] en_data_q[$];
  logic       en_rs_q[$];
  int         en_cyc_q[$];
  int         en_len_q[$];

  always @(negedge clk) begin
    cyc++;
    if (lcd_rw !== 1'b0) rw_bad = 1'b1;
    if (lcd_en && !en_prev) begin
      en_data_q.push_back(lcd_data);
      en_rs_q.push_back(lcd_rs);
      en_cyc_q.push_back(cyc);
      cur_len = 0;
    end
    if (lcd_en) cur_len++;
    else if (en_prev) en_len_q.push_back(cur_len);
    en_prev = lcd_en;
  end

  task automatic clear_mon();
    en_data_q.delete();
    en_rs_q.delete();
    en_cyc_q.delete();
    en_len_q.delete();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300; i++) begin
      if (req_ready === 1'b1) return;
      @(negedge clk);
    end
    check("wait_ready_timeout", 32'd0, 32'd1);
  endtask

  // Called at the negedge right after the last reset edge, rst_n already released.
  task automatic run_init_check(input string tag);
    logic [7:0] exp_init [6];
    int first_done, first_ready;
    exp_init = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    check({tag, "_rst_en"},    32'(lcd_en),    32'd0);
    check({tag, "_rst_rs"},    32'(lcd_rs),    32'd0);
    check({tag, "_rst_data"},  32'(lcd_data),  32'd0);
    check({tag, "_rst_rw"},    32'(lcd_rw),    32'd0);
    check({tag, "_rst_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rst_done"},  32'(init_done), 32'd0);
    #1 clear_mon();
    first_done  = -1;
    first_ready = -1;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (init_done === 1'b1 && first_done < 0) first_done = k;
      if (req_ready === 1'b1 && first_ready < 0) first_ready = k;
    end
    check({tag, "_done_cycle"},  32'(first_done),  32'd97);
    check({tag, "_ready_cycle"}, 32'(first_ready), 32'd97);
    check({tag, "_en_pulses"},   32'(en_data_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < en_data_q.size() && i < en_len_q.size()) begin
        check($sformatf("%s_init%0d_data", tag, i), 32'(en_data_q[i]), 32'(exp_init[i]));
        check($sformatf("%s_init%0d_rs", tag, i),   32'(en_rs_q[i]),   32'd0);
        check($sformatf("%s_init%0d_len", tag, i),  32'(en_len_q[i]),  32'd3);
      end
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         exp_ready;
  } vec_t;

  vec_t vecs [8];

  task automatic do_write_check(input int n, input vec_t v);
    int   rdy_k, en_start, en_len;
    logic hold_ok;
    wait_ready();
    #1;
    req_valid = 1'b1;
    req_rs    = v.rs;
    req_data  = v.data;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_rs    = ~v.rs;
    req_data  = ~v.data;
    rdy_k = -1; en_start = -1; en_len = 0; hold_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (lcd_rs !== v.rs || lcd_data !== v.data) hold_ok = 1'b0;
      if (lcd_en === 1'b1) begin
        if (en_start < 0) en_start = k;
        en_len++;
      end
      if (req_ready === 1'b1) begin
        rdy_k = k;
        break;
      end
    end
    check($sformatf("wr%0d_ready_cycle", n), 32'(rdy_k),    32'(v.exp_ready));
    check($sformatf("wr%0d_en_start", n),    32'(en_start), 32'd2);
    check($sformatf("wr%0d_en_len", n),      32'(en_len),   32'd3);
    check($sformatf("wr%0d_bus_hold", n),    32'(hold_ok),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_q [$];
    logic       exp_rs_q [$];
    logic [7:0] bytes4 [4];
    int         idx;
    int         seen;

    vecs[0] = '{1'b1, 8'h41, 12};
    vecs[1] = '{1'b0, 8'h01, 27};
    vecs[2] = '{1'b1, 8'h01, 12};
    vecs[3] = '{1'b0, 8'h02, 27};
    vecs[4] = '{1'b0, 8'h03, 27};
    vecs[5] = '{1'b0, 8'h04, 12};
    vecs[6] = '{1'b0, 8'h00, 12};
    vecs[7] = '{1'b1, 8'h02, 12};

    // power-on reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_init_check("por");

    for (int i = 0; i < 8; i++) do_write_check(i, vecs[i]);

    // requester holds valid with changing data through a busy write
    wait_ready();
    #1 clear_mon();
    for (int k = 0; k < 30; k++) begin
      req_valid = 1'b1;
      req_rs    = k[0];
      req_data  = 8'(8'h80 + k);
      if (req_ready === 1'b1) begin
        exp_q.push_back(req_data);
        exp_rs_q.push_back(req_rs);
      end
      @(negedge clk);
      #1;
    end
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("hold_accepts", 32'(exp_q.size()), 32'd3);
    check("hold_en_pulses", 32'(en_data_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < en_data_q.size()) begin
        check($sformatf("hold%0d_data", i), 32'(en_data_q[i]), 32'(exp_q[i]));
        check($sformatf("hold%0d_rs", i),   32'(en_rs_q[i]),   32'(exp_rs_q[i]));
      end
    end

    // continuous stream of four bytes
    bytes4 = '{8'h31, 8'h32, 8'h33, 8'h34};
    wait_ready();
    #1 clear_mon();
    rw_bad    = 1'b0;
    idx       = 0;
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = bytes4[0];
    for (int k = 0; k < 100 && idx < 4; k++) begin
      if (req_ready === 1'b1) begin
        @(posedge clk);
        #1;
        idx++;
        if (idx < 4) req_data = bytes4[idx];
        else req_valid = 1'b0;
      end
      @(negedge clk);
      #1;
    end
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("stream_accepts", 32'(idx), 32'd4);
    check("stream_en_pulses", 32'(en_data_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < en_data_q.size()) begin
        check($sformatf("stream%0d_data", i), 32'(en_data_q[i]), 32'(bytes4[i]));
        if (i > 0)
          check($sformatf("stream%0d_spacing", i), 32'(en_cyc_q[i] - en_cyc_q[i-1]), 32'd12);
      end
    end
    check("stream_rw_low", 32'(rw_bad), 32'd0);

    // reset pulse while EN is high
    wait_ready();
    #1;
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (lcd_en === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("midrst_en_seen", 32'(seen), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_en_drop",  32'(lcd_en),    32'd0);
    check("midrst_data",     32'(lcd_data),  32'd0);
    check("midrst_rs",       32'(lcd_rs),    32'd0);
    check("midrst_ready",    32'(req_ready), 32'd0);
    check("midrst_done",     32'(init_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_init_check("midrst");
    do_write_check(8, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
